// File: rtl/mem_bus_arbiter_if.sv
// Master-side bus bundle of mem_bus_arbiter: per-master request, address,
// write strobes and write data toward the arbiter, and grant, read-valid
// and read data back toward the masters. All fields are packed per master.
interface mem_bus_arbiter_if #(
    parameter int NM = 3
);
    logic [NM-1:0]    m_req;
    logic [NM*15-1:0] m_addr;
    logic [NM*2-1:0]  m_wr;
    logic [NM*16-1:0] m_dout;
    logic [NM-1:0]    m_gnt;
    logic [NM-1:0]    m_rdv;
    logic [NM*16-1:0] m_din;

    modport master (
        output m_req, m_addr, m_wr, m_dout,
        input  m_gnt, m_rdv, m_din
    );

    modport slave (
        input  m_req, m_addr, m_wr, m_dout,
        output m_gnt, m_rdv, m_din
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares program memory, data memory and a peripheral
// window between NM bus masters. Each target owns an arbiter (fixed
// priority or round-robin) and an IDLE/BUSY wait-state machine, so accesses
// to different targets proceed in parallel. Unmapped accesses complete at
// once and read back zero.
module mem_bus_arbiter #(
    parameter int          NM        = 3,
    parameter int          PMEM_AW   = 11,
    parameter int          DMEM_AW   = 9,
    parameter logic [15:0] DMEM_BASE = 16'h0200,
    parameter logic [15:0] PER_SIZE  = 16'h0200,
    parameter int          PMEM_WS   = 0,
    parameter int          DMEM_WS   = 0,
    parameter int          PER_WS    = 0,
    parameter int          ARB_MODE  = 0
) (
    input  logic               mclk,
    input  logic               puc_n,
    mem_bus_arbiter_if.slave   mbus,
    output logic [PMEM_AW-1:0] pmem_addr,
    output logic               pmem_cen,
    output logic [1:0]         pmem_wen,
    output logic [15:0]        pmem_din,
    input  logic [15:0]        pmem_dout,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic               dmem_cen,
    output logic [1:0]         dmem_wen,
    output logic [15:0]        dmem_din,
    input  logic [15:0]        dmem_dout,
    output logic [7:0]         per_addr,
    output logic               per_en,
    output logic [1:0]         per_wen,
    output logic [15:0]        per_din,
    input  logic [15:0]        per_dout
);
    // Target codes; also the index of each target's arbiter.
    localparam logic [1:0] T_PER  = 2'd0;
    localparam logic [1:0] T_DMEM = 2'd1;
    localparam logic [1:0] T_PMEM = 2'd2;
    localparam logic [1:0] T_NONE = 2'd3;

    // Window limits as 17-bit word addresses so the end bounds cannot wrap.
    localparam logic [16:0] PER_WEND   = {2'b00, PER_SIZE[15:1]};
    localparam logic [16:0] DMEM_WBASE = {2'b00, DMEM_BASE[15:1]};
    localparam logic [16:0] DMEM_WEND  = DMEM_WBASE + (17'd1 << DMEM_AW);
    localparam logic [16:0] PMEM_WBASE = 17'h08000 - (17'd1 << PMEM_AW);

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t      state_q [3];
    state_t      state_d [3];
    logic [2:0]  cnt_q   [3];
    logic [2:0]  cnt_d   [3];
    logic [1:0]  owner_q [3];
    logic [1:0]  owner_d [3];
    logic [1:0]  ptr_q   [3];
    logic [1:0]  ptr_d   [3];

    logic [1:0]    tgt_of_s  [NM];
    logic [NM-1:0] hit_s     [3];
    logic [1:0]    win_s     [3];
    logic [1:0]    tgt_mst_s [3];
    logic [2:0]    tgt_en_s;
    logic [NM-1:0] gnt_s;
    logic [NM-1:0] rdv_d;
    logic [NM-1:0] rdv_q;
    logic [1:0]    src_d [NM];
    logic [1:0]    src_q [NM];

    // Address decode with PER taking precedence over DMEM over PMEM.
    function automatic logic [1:0] decode(input logic [14:0] a);
        logic [16:0] ax;
        ax = {2'b00, a};
        if (ax < PER_WEND) begin
            decode = T_PER;
        end else if ((ax >= DMEM_WBASE) && (ax < DMEM_WEND)) begin
            decode = T_DMEM;
        end else if (ax >= PMEM_WBASE) begin
            decode = T_PMEM;
        end else begin
            decode = T_NONE;
        end
    endfunction

    // Wait states configured for a target index.
    function automatic int ws_of(input int t);
        case (t)
            0:       ws_of = PER_WS;
            1:       ws_of = DMEM_WS;
            default: ws_of = PMEM_WS;
        endcase
    endfunction

    // Winner among requesters: lowest index, or first after the last winner.
    function automatic logic [1:0] pick(input logic [NM-1:0] req, input logic [1:0] last);
        int   j;
        logic found;
        pick  = 2'd0;
        found = 1'b0;
        for (int k = 0; k < NM; k++) begin
            if (ARB_MODE == 1) begin
                j = (int'(last) + 1 + k) % NM;
            end else begin
                j = k;
            end
            if (!found && req[j]) begin
                pick  = 2'(j);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
    endfunction

    // Decode, per-target arbitration and IDLE/BUSY next-state logic.
    always_comb begin
        gnt_s    = '0;
        tgt_en_s = 3'b000;
        for (int i = 0; i < NM; i++) begin
            tgt_of_s[i] = decode(mbus.m_addr[i*15 +: 15]);
            gnt_s[i]    = mbus.m_req[i] & (tgt_of_s[i] == T_NONE);
        end
        for (int t = 0; t < 3; t++) begin
            state_d[t]   = state_q[t];
            cnt_d[t]     = cnt_q[t];
            owner_d[t]   = owner_q[t];
            ptr_d[t]     = ptr_q[t];
            tgt_mst_s[t] = 2'd0;
            for (int i = 0; i < NM; i++) begin
                hit_s[t][i] = mbus.m_req[i] & (tgt_of_s[i] == 2'(t));
            end
            win_s[t] = pick(hit_s[t], ptr_q[t]);
            case (state_q[t])
                S_IDLE: begin
                    if (|hit_s[t]) begin
                        tgt_en_s[t]  = 1'b1;
                        tgt_mst_s[t] = win_s[t];
                        if (ws_of(t) == 0) begin
                            gnt_s[win_s[t]] = 1'b1;
                            ptr_d[t]        = win_s[t];
                        end else begin
                            // The IDLE cycle is the first of WS+1, so BUSY counts WS-1 down to 0.
                            state_d[t] = S_BUSY;
                            owner_d[t] = win_s[t];
                            cnt_d[t]   = 3'(ws_of(t) - 1);
                        end
                    end else begin
                        cnt_d[t] = 3'd0;
                    end
                end
                S_BUSY: begin
                    if (mbus.m_req[owner_q[t]]) begin
                        tgt_en_s[t]  = 1'b1;
                        tgt_mst_s[t] = owner_q[t];
                        if (cnt_q[t] == 3'd0) begin
                            gnt_s[owner_q[t]] = 1'b1;
                            ptr_d[t]          = owner_q[t];
                            state_d[t]        = S_IDLE;
                        end else begin
                            cnt_d[t] = cnt_q[t] - 3'd1;
                        end
                    end else begin
                        // Owner withdrew: abort without a grant.
                        state_d[t] = S_IDLE;
                        cnt_d[t]   = 3'd0;
                    end
                end
                default: begin
                    state_d[t] = S_IDLE;
                    cnt_d[t]   = 3'd0;
                end
            endcase
        end
        for (int i = 0; i < NM; i++) begin
            rdv_d[i] = gnt_s[i] & (mbus.m_wr[i*2 +: 2] == 2'b00);
            src_d[i] = tgt_of_s[i];
        end
    end

    // Per-target state, wait counter, latched owner and round-robin pointer.
    always_ff @(posedge mclk or negedge puc_n) begin
        if (!puc_n) begin
            for (int t = 0; t < 3; t++) begin
                state_q[t] <= S_IDLE;
                cnt_q[t]   <= 3'd0;
                owner_q[t] <= 2'd0;
                ptr_q[t]   <= 2'(NM - 1);
            end
        end else begin
            for (int t = 0; t < 3; t++) begin
                state_q[t] <= state_d[t];
                cnt_q[t]   <= cnt_d[t];
                owner_q[t] <= owner_d[t];
                ptr_q[t]   <= ptr_d[t];
            end
        end
    end

    // Read-valid and read-source tracking, one cycle behind the grant.
    always_ff @(posedge mclk or negedge puc_n) begin
        if (!puc_n) begin
            rdv_q <= '0;
            for (int i = 0; i < NM; i++) begin
                src_q[i] <= T_NONE;
            end
        end else begin
            rdv_q <= rdv_d;
            for (int i = 0; i < NM; i++) begin
                src_q[i] <= src_d[i];
            end
        end
    end

    // Master-side returns: grants gated by reset, read data zero unless valid.
    always_comb begin
        mbus.m_gnt = gnt_s & {NM{puc_n}};
        mbus.m_rdv = rdv_q;
        mbus.m_din = '0;
        for (int i = 0; i < NM; i++) begin
            if (rdv_q[i]) begin
                case (src_q[i])
                    T_PER:   mbus.m_din[i*16 +: 16] = per_dout;
                    T_DMEM:  mbus.m_din[i*16 +: 16] = dmem_dout;
                    T_PMEM:  mbus.m_din[i*16 +: 16] = pmem_dout;
                    default: mbus.m_din[i*16 +: 16] = 16'h0000;
                endcase
            end else begin
                mbus.m_din[i*16 +: 16] = 16'h0000;
            end
        end
    end

    // Target ports driven from whichever master currently owns each target.
    always_comb begin
        per_en    = tgt_en_s[0] & puc_n;
        per_addr  = mbus.m_addr[int'(tgt_mst_s[0])*15 +: 8];
        per_wen   = per_en ? mbus.m_wr[int'(tgt_mst_s[0])*2 +: 2] : 2'b00;
        per_din   = mbus.m_dout[int'(tgt_mst_s[0])*16 +: 16];

        dmem_cen  = ~(tgt_en_s[1] & puc_n);
        dmem_addr = DMEM_AW'(mbus.m_addr[int'(tgt_mst_s[1])*15 +: 15] - DMEM_WBASE[14:0]);
        dmem_wen  = dmem_cen ? 2'b11 : ~mbus.m_wr[int'(tgt_mst_s[1])*2 +: 2];
        dmem_din  = mbus.m_dout[int'(tgt_mst_s[1])*16 +: 16];

        pmem_cen  = ~(tgt_en_s[2] & puc_n);
        pmem_addr = PMEM_AW'(mbus.m_addr[int'(tgt_mst_s[2])*15 +: 15] - PMEM_WBASE[14:0]);
        pmem_wen  = pmem_cen ? 2'b11 : ~mbus.m_wr[int'(tgt_mst_s[2])*2 +: 2];
        pmem_din  = mbus.m_dout[int'(tgt_mst_s[2])*16 +: 16];
    end
endmodule
